// File: rtl/flip_flop_d_reset.sv
// D-type register of parameterised width with synchronous, active-high reset.
// Q comes straight from the storage register; D and rst only matter at rising
// clk edges, and rst wins over D when both are sampled.
module flip_flop_d_reset #(
  parameter int unsigned          WIDTH   = 1,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // Declaration initialiser gives the simulated power-up value before the first edge.
  logic [WIDTH-1:0] q_reg = RST_VAL;

  // Capture D on each rising edge; a sampled rst loads RST_VAL instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= RST_VAL;
    end else begin
      q_reg <= D;
    end
  end

  assign Q = q_reg;

endmodule

// File: tb/tb_flip_flop_d_reset.sv
// Directed bench for flip_flop_d_reset: one default 1-bit instance and one
// 8-bit instance with a non-zero reset value, sharing clock and reset.
module tb_flip_flop_d_reset;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d1  = 1'b0;
  logic       q1;
  logic [7:0] d8  = 8'h00;
  logic [7:0] q8;

  int total = 0;
  int bad   = 0;

  // 100 ns period, rising edges at 50, 150, 250 ...
  always #50 clk = ~clk;

  flip_flop_d_reset u_w1 (
    .clk (clk),
    .rst (rst),
    .D   (d1),
    .Q   (q1)
  );

  flip_flop_d_reset #(
    .WIDTH   (8),
    .RST_VAL (8'hA5)
  ) u_w8 (
    .clk (clk),
    .rst (rst),
    .D   (d8),
    .Q   (q8)
  );

  // Register value before any clock edge.
  task automatic test_power_up();
    #10;
    total++;
    if (q1 !== 1'b0) begin
      bad++;
      $display("FAIL power_up_w1: got %b expected %b", q1, 1'b0);
    end
    total++;
    if (q8 !== 8'hA5) begin
      bad++;
      $display("FAIL power_up_w8: got %h expected %h", q8, 8'hA5);
    end
  endtask

  // Reset sampled at an edge loads RST_VAL even with all-ones data.
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    d1  = 1'b1;
    d8  = 8'hFF;
    @(posedge clk); #1;
    total++;
    if (q1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_w1: got %b expected %b", q1, 1'b0);
    end
    total++;
    if (q8 !== 8'hA5) begin
      bad++;
      $display("FAIL reset_w8: got %h expected %h", q8, 8'hA5);
    end
  endtask

  // D=0 for 5 cycles, then D rises: Q follows exactly one edge later.
  task automatic test_capture_high();
    @(negedge clk);
    rst = 1'b0;
    d1  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (q1 !== 1'b0) begin
        bad++;
        $display("FAIL capture_high_low_phase[%0d]: got %b expected %b", i, q1, 1'b0);
      end
    end
    @(negedge clk);
    d1 = 1'b1;
    #10;
    total++;
    if (q1 !== 1'b0) begin
      bad++;
      $display("FAIL capture_high_before_edge: got %b expected %b", q1, 1'b0);
    end
    @(posedge clk); #1;
    total++;
    if (q1 !== 1'b1) begin
      bad++;
      $display("FAIL capture_high_after_edge: got %b expected %b", q1, 1'b1);
    end
  endtask

  // With Q=1 and D=1, rst held for 2 cycles forces and keeps Q=0.
  task automatic test_reset_override();
    @(negedge clk);
    rst = 1'b1;
    #10;
    total++;
    if (q1 !== 1'b1) begin
      bad++;
      $display("FAIL reset_between_edges: got %b expected %b", q1, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (q1 !== 1'b0) begin
        bad++;
        $display("FAIL reset_override[%0d]: got %b expected %b", i, q1, 1'b0);
      end
    end
  endtask

  // Releasing rst with D=1: Q=1 at the very first edge with rst=0.
  task automatic test_reset_release();
    @(negedge clk);
    rst = 1'b0;
    #10;
    total++;
    if (q1 !== 1'b0) begin
      bad++;
      $display("FAIL release_before_edge: got %b expected %b", q1, 1'b0);
    end
    @(posedge clk); #1;
    total++;
    if (q1 !== 1'b1) begin
      bad++;
      $display("FAIL release_first_edge: got %b expected %b", q1, 1'b1);
    end
  endtask

  // D falls mid-cycle: Q holds 1 until the next rising edge.
  task automatic test_capture_low();
    @(negedge clk);
    d1 = 1'b0;
    #20;
    total++;
    if (q1 !== 1'b1) begin
      bad++;
      $display("FAIL capture_low_mid_cycle: got %b expected %b", q1, 1'b1);
    end
    @(posedge clk); #1;
    total++;
    if (q1 !== 1'b0) begin
      bad++;
      $display("FAIL capture_low_after_edge: got %b expected %b", q1, 1'b0);
    end
    @(negedge clk);
    d1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if (q1 !== 1'b1) begin
      bad++;
      $display("FAIL capture_low_restore: got %b expected %b", q1, 1'b1);
    end
  endtask

  // rst pulse shorter than a period, never present at a rising edge.
  task automatic test_mid_cycle_rst();
    @(negedge clk);
    #10;
    rst = 1'b1;
    #10;
    total++;
    if (q1 !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst_during_pulse: got %b expected %b", q1, 1'b1);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (q1 !== 1'b1) begin
        bad++;
        $display("FAIL mid_rst_after_edge[%0d]: got %b expected %b", i, q1, 1'b1);
      end
    end
  endtask

  // 8-bit capture of several patterns, then reset to A5 and release.
  task automatic test_width8();
    logic [7:0] pats [5];
    logic [7:0] prev;
    pats[0] = 8'h3C;
    pats[1] = 8'hC3;
    pats[2] = 8'h00;
    pats[3] = 8'hFF;
    pats[4] = 8'h5A;
    prev = q8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d8 = pats[i];
      #10;
      total++;
      if (q8 !== prev) begin
        bad++;
        $display("FAIL w8_hold_before_edge[%0d]: got %h expected %h", i, q8, prev);
      end
      @(posedge clk); #1;
      total++;
      if (q8 !== pats[i]) begin
        bad++;
        $display("FAIL w8_capture[%0d]: got %h expected %h", i, q8, pats[i]);
      end
      prev = pats[i];
    end
    @(negedge clk);
    d8 = 8'h3C;
    @(posedge clk); #1;
    total++;
    if (q8 !== 8'h3C) begin
      bad++;
      $display("FAIL w8_capture_3c: got %h expected %h", q8, 8'h3C);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (q8 !== 8'hA5) begin
      bad++;
      $display("FAIL w8_reset: got %h expected %h", q8, 8'hA5);
    end
    @(posedge clk); #1;
    total++;
    if (q8 !== 8'hA5) begin
      bad++;
      $display("FAIL w8_reset_held: got %h expected %h", q8, 8'hA5);
    end
    @(negedge clk);
    rst = 1'b0;
    d8  = 8'h81;
    @(posedge clk); #1;
    total++;
    if (q8 !== 8'h81) begin
      bad++;
      $display("FAIL w8_release: got %h expected %h", q8, 8'h81);
    end
  endtask

  initial begin
    test_power_up();
    test_reset();
    test_capture_high();
    test_reset_override();
    test_reset_release();
    test_capture_low();
    test_mid_cycle_rst();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flip_flop_d_reset.md
FLIP_FLOP_D_RESET -- requirements
Module: flip_flop_d_reset

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the data width of D and Q in bits (legal range 1..64).
REQ-002 The block SHALL have parameter RST_VAL, default all-zeros (WIDTH bits), giving the value loaded into Q by reset.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port D, input, WIDTH, the data to be captured.
REQ-006 The block SHALL have port Q, output, WIDTH, the registered data.

Function
REQ-007 On each rising clk edge with rst=0, Q SHALL take the value D had just before that edge.
REQ-008 Capture latency SHALL be exactly one clock edge, D to Q.
REQ-009 Q SHALL change only on rising clk edges; D or rst changes between edges SHALL have no effect on Q until the next rising edge.
REQ-010 Q SHALL be driven directly from the storage register, with no combinational path from D or rst to Q.
REQ-011 If rst=1 at a rising edge, rst SHALL take priority over D regardless of D's value.
REQ-012 A WIDTH-bit D SHALL be captured bit-for-bit, with no truncation, extension or inversion.
REQ-013 Holding D constant across many edges SHALL keep Q constant, with no glitches at the edges.
REQ-014 Unknown (X) values on D SHALL propagate to Q at the next edge; the block SHALL NOT mask them.

Reset
REQ-015 When rst=1 at a rising clk edge, Q SHALL become RST_VAL (0 at defaults) at that edge.
REQ-016 Assertion of rst between edges SHALL NOT change Q; reset is strictly synchronous.
REQ-017 While rst stays 1, Q SHALL hold RST_VAL on every edge.
REQ-018 At the first rising edge with rst=0 after reset, Q SHALL capture the current D, with no extra recovery cycles.
REQ-019 The register SHALL power up, in simulation, to RST_VAL before the first clk edge.

Verification
Clock period for the bench is 100 ns; rst=0 unless stated.
REQ-020 Capture high: D=0 for 5 cycles, then D=1 -> Q=0 through those cycles, then Q=1 at the first rising edge after D rises.
REQ-021 Reset overrides data: D=1 and Q=1, then rst=1 for 2 cycles -> Q=0 at the first edge with rst=1, and Q stays 0 for both cycles.
REQ-022 Reset release: rst falls to 0 while D=1 -> Q=1 at the first rising edge with rst=0.
REQ-023 Capture low: D changes 1->0 mid-cycle -> Q stays 1 until the next rising edge, then Q=0.
REQ-024 Mid-cycle rst pulse: rst=1 for less than one period, never sampled at a rising edge, with D=1 -> Q stays 1 throughout.
REQ-025 Width check (WIDTH=8, RST_VAL=8'hA5): D=8'h3C -> Q=8'h3C after one edge; then rst=1 -> Q=8'hA5 at that edge.
